uart_rx: RTL

APB responder that receives serial bytes on a single RX line, buffers them in a small FIFO and exposes them to the CPU through four 32-bit registers. It is the receive-side counterpart of the console UART. It sits on the SoC APB bus as an additional peripheral slot, beside sram, sys_sram and uart, and drives an optional level interrupt.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// APB slot bundle between the SoC decoder and the uart_rx peripheral.
interface uart_rx_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/uart_rx.sv
// Serial byte receiver with a small FIFO, read by the CPU over APB.
module uart_rx #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic     clk,
  input  logic     rts,
  uart_rx_if.slave bus,
  input  logic     rx,
  output logic     irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  // The divisor never drops below 4 so the half-bit point stays >= 1.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd4) ? 16'd4 : d;
  endfunction

  // bus decode
  logic        access, bus_err, wr_en, rd_en, pop, clr_wr;
  logic [1:0]  reg_sel;
  logic [31:0] rd_word, status_word;
  logic [15:0] div_wr;
  logic        unused_bus;

  // control registers
  logic        rx_en, irq_en;
  logic [15:0] div_reg;
  logic        overrun, frame_err;

  // fifo
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, not_empty, do_push, ovr_set;

  // receiver
  logic        rx_p0, rx_p1, rx_s;
  state_t      state, state_nx;
  logic [15:0] div_q, bit_cnt, half_m1, full_m1;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tick, start_go, shift_en, push_req, frame_set;

  assign unused_bus = ^{bus.paddr, bus.pdata, bus.pstb};

  assign access      = bus.psel & bus.penable;
  assign reg_sel     = bus.paddr[3:2];
  assign bus_err     = access & ((bus.paddr[1:0] != 2'b00) | (bus.pwrite & (reg_sel == 2'd0)));
  assign wr_en       = access & bus.pwrite & ~bus_err;
  assign rd_en       = access & ~bus.pwrite & ~bus_err;
  assign pop         = rd_en & (reg_sel == 2'd0) & not_empty;
  assign clr_wr      = wr_en & (reg_sel == 2'd1) & bus.pstb[0];
  assign bus.pready  = access;
  assign bus.perr    = bus_err;

  assign div_wr = {bus.pstb[1] ? bus.pdata[15:8] : div_reg[15:8],
                   bus.pstb[0] ? bus.pdata[7:0]  : div_reg[7:0]};

  assign full        = (count == CW'(FIFO_DEPTH));
  assign not_empty   = (count != '0);
  assign do_push     = push_req & ~full;
  assign ovr_set     = push_req & full;
  assign status_word = {16'd0, 8'(count), 4'd0, frame_err, overrun, full, not_empty};

  // Read mux: only a decoded access phase drives prdata, otherwise it is 0.
  always_comb begin
    rd_word = 32'd0;
    if (rd_en) begin
      case (reg_sel)
        2'd0:    if (not_empty) rd_word = {1'b1, 23'd0, mem[rd_ptr]};
        2'd1:    rd_word = status_word;
        2'd2:    rd_word = {30'd0, irq_en, rx_en};
        default: rd_word = {16'd0, div_reg};
      endcase
    end
  end

  assign bus.prdata = DATA_WIDTH'(rd_word);

  // CTRL and DIV writable fields.
  always_ff @(posedge clk) begin
    if (rts) begin
      rx_en   <= 1'b1;
      irq_en  <= 1'b0;
      div_reg <= 16'(CLKS_PER_BIT);
    end else begin
      if (wr_en && (reg_sel == 2'd2) && bus.pstb[0]) begin
        rx_en  <= bus.pdata[0];
        irq_en <= bus.pdata[1];
      end
      if (wr_en && (reg_sel == 2'd3))
        div_reg <= clamp_div(div_wr);
    end
  end

  // Sticky error flags; a new event in the same cycle wins over a W1C clear.
  always_ff @(posedge clk) begin
    if (rts) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)                      overrun   <= 1'b1;
      else if (clr_wr && bus.pdata[2])  overrun   <= 1'b0;
      if (frame_set)                    frame_err <= 1'b1;
      else if (clr_wr && bus.pdata[3])  frame_err <= 1'b0;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk) begin
    if (rts) irq <= 1'b0;
    else     irq <= irq_en & not_empty;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (rts) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  // Two-flop synchronizer for the asynchronous rx line, idling high.
  always_ff @(posedge clk) begin
    if (rts) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s    = rx_p1;
  assign half_m1 = (div_q >> 1) - 16'd1;
  assign full_m1 = div_q - 16'd1;
  assign tick    = (state == S_START) ? (bit_cnt == half_m1) :
                   ((state == S_DATA) || (state == S_STOP)) ? (bit_cnt == full_m1) : 1'b0;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rts) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Receiver next state; clearing rx_en drops back to IDLE from anywhere.
  always_comb begin
    state_nx = state;
    if (!rx_en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (!rx_s) state_nx = S_START;
        S_START:     if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
        S_DATA:      if (tick && (bit_idx == 3'd7)) state_nx = S_STOP;
        S_STOP:      if (tick) state_nx = rx_s ? S_IDLE : S_WAIT_HIGH;
        S_WAIT_HIGH: if (rx_s) state_nx = S_IDLE;
        default:     state_nx = S_IDLE;
      endcase
    end
  end

  // Receiver strobes towards the datapath, FIFO and flags.
  always_comb begin
    start_go  = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (rx_en) begin
      case (state)
        S_IDLE: start_go = ~rx_s;
        S_DATA: shift_en = tick;
        S_STOP: begin
          push_req  = tick & rx_s;
          frame_set = tick & ~rx_s;
        end
        default: ;
      endcase
    end
  end

  // Bit timing counter and bit index.
  always_ff @(posedge clk) begin
    if (rts) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if ((state == S_IDLE) || tick) bit_cnt <= '0;
      else                           bit_cnt <= bit_cnt + 16'd1;
      if (state == S_IDLE)           bit_idx <= '0;
      else if (shift_en)             bit_idx <= bit_idx + 3'd1;
    end
  end

  // Frame divisor snapshot and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (start_go) div_q <= div_reg;
    if (shift_en) shift <= {rx_s, shift[7:1]};
  end
endmodule
